renode_bus_arbiter: RTL and testbench

Shares the single Renode bus-controller channel between RequestersCount independent requesters, for example the Renode message handler and local DMA-style agents. The block performs round-robin arbitration and issues one transaction at a time to the downstream controller port. It enforces a per-transaction timeout and returns an ok, error or timeout status to the granted requester. It sits between request sources and the bus-controller adapter, in place of direct request-to-bus calls.

---
 rtl/renode_pkg.sv | 24 ++
 rtl/renode_rr_arbiter.sv | 45 ++++
 rtl/renode_bus_arbiter.sv | 167 ++++++++++++++++
 tb/tb_renode_bus_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/renode_pkg.sv
// Shared types for the Renode bus-controller arbitration slice.
//   arb_state_e   : transaction FSM states (IDLE -> ISSUE -> WAIT -> RESPOND)
//   rsp_status_e  : status returned to the granted requester
//   index_width() : width of a requester index, at least one bit
package renode_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT    = 2'd2,
        RESPOND = 2'd3
    } arb_state_e;

    typedef enum logic [1:0] {
        RspOk      = 2'd0,
        RspError   = 2'd1,
        RspTimeout = 2'd2
    } rsp_status_e;

    function automatic int unsigned index_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/renode_rr_arbiter.sv
// Combinational round-robin pick among a request vector.
// The search starts at ptr_i and wraps; the pointer register is owned by the parent.
//   req_i    : per-requester request bits
//   ptr_i    : index to search from
//   grant_o  : one-hot grant (all zero when nothing is requested)
//   winner_o : index of the granted requester
//   any_o    : at least one request present
module renode_rr_arbiter
    import renode_pkg::*;
#(
    parameter int unsigned RequestersCount = 2,
    parameter int unsigned IdxW            = index_width(RequestersCount)
) (
    input  logic [RequestersCount-1:0] req_i,
    input  logic [IdxW-1:0]            ptr_i,
    output logic [RequestersCount-1:0] grant_o,
    output logic [IdxW-1:0]            winner_o,
    output logic                       any_o
);

    // Walk the requesters in priority order ptr, ptr+1, ... (mod count); the
    // inner compare loop keeps every vector index constant.
    always_comb begin
        logic        found;
        int unsigned idx;
        found    = 1'b0;
        idx      = 0;
        winner_o = '0;
        for (int unsigned i = 0; i < RequestersCount; i++) begin
            idx = (32'(ptr_i) + i) % RequestersCount;
            for (int unsigned j = 0; j < RequestersCount; j++) begin
                if (!found && (j == idx) && req_i[j]) begin
                    found    = 1'b1;
                    winner_o = IdxW'(j);
                end
            end
        end
        grant_o = '0;
        for (int unsigned j = 0; j < RequestersCount; j++) begin
            grant_o[j] = found && (32'(winner_o) == j);
        end
        any_o = found;
    end

endmodule

// File: rtl/renode_bus_arbiter.sv
// Shares one Renode bus-controller channel among RequestersCount requesters.
// Round-robin grant, one outstanding transaction, per-transaction timeout.
//   clk, rst_n                     : clock, async active-low reset
//   req_valid/write/address/wdata  : packed per-requester request fields
//   req_ready                      : one-hot accept strobe (combinational in IDLE)
//   rsp_valid/rdata/status         : one-cycle response to the granted requester
//   bus_valid/write/address/wdata  : downstream issue, held until bus_ready
//   bus_ready, bus_rsp_*           : downstream handshake and completion
//   busy                           : transaction outstanding
module renode_bus_arbiter
    import renode_pkg::*;
#(
    parameter int unsigned RequestersCount = 2,
    parameter int unsigned AddressWidth    = 32,
    parameter int unsigned DataWidth       = 32,
    parameter int unsigned TimeoutCycles   = 100
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [RequestersCount-1:0]           req_valid,
    input  logic [RequestersCount-1:0]           req_write,
    input  logic [RequestersCount*AddressWidth-1:0] req_address,
    input  logic [RequestersCount*DataWidth-1:0] req_wdata,
    output logic [RequestersCount-1:0]           req_ready,
    output logic [RequestersCount-1:0]           rsp_valid,
    output logic [DataWidth-1:0]                 rsp_rdata,
    output logic [1:0]                           rsp_status,
    output logic                                 bus_valid,
    output logic                                 bus_write,
    output logic [AddressWidth-1:0]              bus_address,
    output logic [DataWidth-1:0]                 bus_wdata,
    input  logic                                 bus_ready,
    input  logic                                 bus_rsp_valid,
    input  logic                                 bus_rsp_error,
    input  logic [DataWidth-1:0]                 bus_rsp_rdata,
    output logic                                 busy
);

    localparam int unsigned IdxW = index_width(RequestersCount);
    localparam int unsigned CntW = $clog2(TimeoutCycles + 1);

    // Reset asserts asynchronously but releases two clocks after rst_n rises,
    // so no state flop leaves reset on a clock edge it was not set up for.
    logic [1:0] rst_sync_q;
    logic       arst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync_q <= '0;
        else        rst_sync_q <= {rst_sync_q[0], 1'b1};
    end

    assign arst_n = rst_sync_q[1];

    arb_state_e                  state_q, state_d;
    logic [IdxW-1:0]             ptr_q, ptr_d;
    logic [RequestersCount-1:0]  grant_q, grant_d;
    logic                        write_q, write_d;
    logic [AddressWidth-1:0]     addr_q, addr_d;
    logic [DataWidth-1:0]        wdata_q, wdata_d;
    logic [CntW-1:0]             cnt_q, cnt_d;
    logic [DataWidth-1:0]        rdata_q, rdata_d;
    rsp_status_e                 status_q, status_d;

    logic [RequestersCount-1:0]  arb_grant;
    logic [IdxW-1:0]             arb_winner;
    logic                        arb_any;
    logic                        expire;

    renode_rr_arbiter #(
        .RequestersCount(RequestersCount),
        .IdxW           (IdxW)
    ) u_rr (
        .req_i   (req_valid),
        .ptr_i   (ptr_q),
        .grant_o (arb_grant),
        .winner_o(arb_winner),
        .any_o   (arb_any)
    );

    // The counter is 0 on the first ISSUE cycle, so this is the last allowed cycle.
    assign expire = (cnt_q == CntW'(TimeoutCycles - 1));

    // Transaction FSM. A response seen in the expiry cycle takes priority over
    // the timeout; responses outside ISSUE/WAIT are dropped.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        grant_d  = grant_q;
        write_d  = write_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        cnt_d    = cnt_q;
        rdata_d  = rdata_q;
        status_d = status_q;
        unique case (state_q)
            IDLE: begin
                if (arb_any) begin
                    state_d = ISSUE;
                    grant_d = arb_grant;
                    write_d = req_write[arb_winner];
                    addr_d  = req_address[arb_winner*AddressWidth +: AddressWidth];
                    wdata_d = req_wdata[arb_winner*DataWidth +: DataWidth];
                    ptr_d   = (arb_winner == IdxW'(RequestersCount - 1)) ? '0
                                                                         : arb_winner + IdxW'(1);
                    cnt_d   = '0;
                end
            end
            ISSUE, WAIT: begin
                cnt_d = cnt_q + CntW'(1);
                if (bus_rsp_valid && (state_q == WAIT || bus_ready)) begin
                    state_d  = RESPOND;
                    status_d = bus_rsp_error ? RspError : RspOk;
                    rdata_d  = (bus_rsp_error || write_q) ? '0 : bus_rsp_rdata;
                end else if (expire) begin
                    state_d  = RESPOND;
                    status_d = RspTimeout;
                    rdata_d  = '0;
                end else if (state_q == ISSUE && bus_ready) begin
                    state_d = WAIT;
                end
            end
            RESPOND: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    // All transaction state, including the round-robin pointer.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            grant_q  <= '0;
            write_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            cnt_q    <= '0;
            rdata_q  <= '0;
            status_q <= RspOk;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            grant_q  <= grant_d;
            write_q  <= write_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
            status_q <= status_d;
        end
    end

    // Outputs are decoded from the state so every one is 0 while in reset;
    // req_ready is also held off until the reset release has completed.
    assign req_ready   = (state_q == IDLE && arst_n) ? arb_grant : '0;
    assign bus_valid   = (state_q == ISSUE);
    assign bus_write   = (state_q == ISSUE) && write_q;
    assign bus_address = (state_q == ISSUE) ? addr_q  : '0;
    assign bus_wdata   = (state_q == ISSUE) ? wdata_q : '0;
    assign rsp_valid   = (state_q == RESPOND) ? grant_q : '0;
    assign rsp_rdata   = (state_q == RESPOND) ? rdata_q : '0;
    assign rsp_status  = (state_q == RESPOND) ? status_q : 2'd0;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_renode_bus_arbiter.sv
// Self-checking bench for renode_bus_arbiter with three requesters and a
// ten-cycle timeout: table-driven round-robin vectors followed by directed
// sequences for read latency, timeout, bus error, response/timeout collision
// and reset in the middle of a transaction.
module tb_renode_bus_arbiter;

    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_write;
    logic [N*AW-1:0] req_address;
    logic [N*DW-1:0] req_wdata;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    rsp_valid;
    logic [DW-1:0]   rsp_rdata;
    logic [1:0]      rsp_status;
    logic            bus_valid;
    logic            bus_write;
    logic [AW-1:0]   bus_address;
    logic [DW-1:0]   bus_wdata;
    logic            bus_ready;
    logic            bus_rsp_valid;
    logic            bus_rsp_error;
    logic [DW-1:0]   bus_rsp_rdata;
    logic            busy;

    int errors = 0;
    int checks = 0;

    renode_bus_arbiter #(
        .RequestersCount(N),
        .AddressWidth   (AW),
        .DataWidth      (DW),
        .TimeoutCycles  (10)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_write    (req_write),
        .req_address  (req_address),
        .req_wdata    (req_wdata),
        .req_ready    (req_ready),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_status   (rsp_status),
        .bus_valid    (bus_valid),
        .bus_write    (bus_write),
        .bus_address  (bus_address),
        .bus_wdata    (bus_wdata),
        .bus_ready    (bus_ready),
        .bus_rsp_valid(bus_rsp_valid),
        .bus_rsp_error(bus_rsp_error),
        .bus_rsp_rdata(bus_rsp_rdata),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  reqValid;
        logic [2:0]  expReqReady;
        logic        expBusValid;
        logic [31:0] expBusAddress;
        logic [2:0]  expRspValid;
        logic [31:0] expRspRdata;
        logic        expBusy;
    } vec_t;

    vec_t tbl[27];

    function automatic vec_t mk(input logic [2:0] rv, input logic [2:0] rdy, input logic bv,
                                input logic [31:0] ba, input logic [2:0] sv,
                                input logic [31:0] rd, input logic by);
        vec_t v;
        v.reqValid      = rv;
        v.expReqReady   = rdy;
        v.expBusValid   = bv;
        v.expBusAddress = ba;
        v.expRspValid   = sv;
        v.expRspRdata   = rd;
        v.expBusy       = by;
        return v;
    endfunction

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [2:0] rv, input logic rdy, input logic rspV,
                                 input logic rspE, input logic [31:0] rspD);
        req_valid     = rv;
        bus_ready     = rdy;
        bus_rsp_valid = rspV;
        bus_rsp_error = rspE;
        bus_rsp_rdata = rspD;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    initial begin
        // Round-robin with all three requesting, then sparse request patterns.
        // The bus answers immediately with 0xA0, so each grant takes 3 cycles.
        tbl[0]  = mk(3'b111, 3'b001, 0, 32'h0,    3'b000, 32'h0,  0);
        tbl[1]  = mk(3'b111, 3'b000, 1, 32'h1000, 3'b000, 32'h0,  1);
        tbl[2]  = mk(3'b111, 3'b000, 0, 32'h0,    3'b001, 32'hA0, 1);
        tbl[3]  = mk(3'b111, 3'b010, 0, 32'h0,    3'b000, 32'h0,  0);
        tbl[4]  = mk(3'b111, 3'b000, 1, 32'h1100, 3'b000, 32'h0,  1);
        tbl[5]  = mk(3'b111, 3'b000, 0, 32'h0,    3'b010, 32'hA0, 1);
        tbl[6]  = mk(3'b111, 3'b100, 0, 32'h0,    3'b000, 32'h0,  0);
        tbl[7]  = mk(3'b111, 3'b000, 1, 32'h2000, 3'b000, 32'h0,  1);
        tbl[8]  = mk(3'b111, 3'b000, 0, 32'h0,    3'b100, 32'hA0, 1);
        tbl[9]  = mk(3'b111, 3'b001, 0, 32'h0,    3'b000, 32'h0,  0);
        tbl[10] = mk(3'b111, 3'b000, 1, 32'h1000, 3'b000, 32'h0,  1);
        tbl[11] = mk(3'b111, 3'b000, 0, 32'h0,    3'b001, 32'hA0, 1);
        tbl[12] = mk(3'b111, 3'b010, 0, 32'h0,    3'b000, 32'h0,  0);
        tbl[13] = mk(3'b111, 3'b000, 1, 32'h1100, 3'b000, 32'h0,  1);
        tbl[14] = mk(3'b111, 3'b000, 0, 32'h0,    3'b010, 32'hA0, 1);
        tbl[15] = mk(3'b111, 3'b100, 0, 32'h0,    3'b000, 32'h0,  0);
        tbl[16] = mk(3'b111, 3'b000, 1, 32'h2000, 3'b000, 32'h0,  1);
        tbl[17] = mk(3'b111, 3'b000, 0, 32'h0,    3'b100, 32'hA0, 1);
        tbl[18] = mk(3'b000, 3'b000, 0, 32'h0,    3'b000, 32'h0,  0);
        tbl[19] = mk(3'b110, 3'b010, 0, 32'h0,    3'b000, 32'h0,  0);
        tbl[20] = mk(3'b100, 3'b000, 1, 32'h1100, 3'b000, 32'h0,  1);
        tbl[21] = mk(3'b100, 3'b000, 0, 32'h0,    3'b010, 32'hA0, 1);
        tbl[22] = mk(3'b101, 3'b100, 0, 32'h0,    3'b000, 32'h0,  0);
        tbl[23] = mk(3'b000, 3'b000, 1, 32'h2000, 3'b000, 32'h0,  1);
        tbl[24] = mk(3'b000, 3'b000, 0, 32'h0,    3'b100, 32'hA0, 1);
        tbl[25] = mk(3'b000, 3'b000, 0, 32'h0,    3'b000, 32'h0,  0);
        tbl[26] = mk(3'b000, 3'b000, 0, 32'h0,    3'b000, 32'h0,  0);

        req_address = {32'h2000, 32'h1100, 32'h1000};
        req_wdata   = {32'h55, 32'h44, 32'h33};
        req_write   = 3'b000;
        applyStimulus(3'b000, 0, 0, 0, 32'h0);

        // Reset state.
        rst_n = 1'b0;
        tick();
        tick();
        checkOutput("reset busy", 32'(busy), 32'h0);
        checkOutput("reset bus_valid", 32'(bus_valid), 32'h0);
        checkOutput("reset rsp_valid", 32'(rsp_valid), 32'h0);
        checkOutput("reset rsp_status", 32'(rsp_status), 32'h0);
        rst_n = 1'b1;
        repeat (4) tick();

        // Table vectors.
        for (int i = 0; i < 27; i++) begin
            applyStimulus(tbl[i].reqValid, 1, 1, 0, 32'hA0);
            #1;
            checkOutput($sformatf("vec%0d req_ready", i), 32'(req_ready), 32'(tbl[i].expReqReady));
            checkOutput($sformatf("vec%0d bus_valid", i), 32'(bus_valid), 32'(tbl[i].expBusValid));
            checkOutput($sformatf("vec%0d bus_address", i), bus_address, tbl[i].expBusAddress);
            checkOutput($sformatf("vec%0d rsp_valid", i), 32'(rsp_valid), 32'(tbl[i].expRspValid));
            checkOutput($sformatf("vec%0d rsp_rdata", i), rsp_rdata, tbl[i].expRspRdata);
            checkOutput($sformatf("vec%0d rsp_status", i), 32'(rsp_status), 32'h0);
            checkOutput($sformatf("vec%0d busy", i), 32'(busy), 32'(tbl[i].expBusy));
            tick();
        end

        // Single read, response five cycles after issue.
        applyStimulus(3'b001, 0, 0, 0, 32'h0);
        #1;
        checkOutput("read req_ready", 32'(req_ready), 32'h1);
        tick();
        applyStimulus(3'b000, 1, 0, 0, 32'h0);
        #1;
        checkOutput("read bus_address", bus_address, 32'h1000);
        checkOutput("read bus_write", 32'(bus_write), 32'h0);
        tick();
        applyStimulus(3'b000, 0, 0, 0, 32'h0);
        repeat (4) begin
            #1;
            checkOutput("read wait rsp_valid", 32'(rsp_valid), 32'h0);
            tick();
        end
        applyStimulus(3'b000, 0, 1, 0, 32'hDEADBEEF);
        tick();
        applyStimulus(3'b000, 0, 0, 0, 32'h0);
        #1;
        checkOutput("read rsp_valid", 32'(rsp_valid), 32'h1);
        checkOutput("read rsp_status", 32'(rsp_status), 32'h0);
        checkOutput("read rsp_rdata", rsp_rdata, 32'hDEADBEEF);
        checkOutput("read busy in respond", 32'(busy), 32'h1);
        tick();
        #1;
        checkOutput("read busy after", 32'(busy), 32'h0);
        checkOutput("read rsp_valid after", 32'(rsp_valid), 32'h0);
        tick();

        // Timeout: requester 1, bus never accepts.
        applyStimulus(3'b010, 0, 0, 0, 32'h0);
        #1;
        checkOutput("timeout req_ready", 32'(req_ready), 32'h2);
        tick();
        applyStimulus(3'b000, 0, 0, 0, 32'h0);
        for (int k = 0; k < 10; k++) begin
            #1;
            checkOutput($sformatf("timeout cycle%0d bus_valid", k), 32'(bus_valid), 32'h1);
            checkOutput($sformatf("timeout cycle%0d rsp_valid", k), 32'(rsp_valid), 32'h0);
            tick();
        end
        applyStimulus(3'b000, 0, 1, 0, 32'hBAD0BAD0);
        #1;
        checkOutput("timeout rsp_valid", 32'(rsp_valid), 32'h2);
        checkOutput("timeout rsp_status", 32'(rsp_status), 32'h2);
        checkOutput("timeout rsp_rdata", rsp_rdata, 32'h0);
        checkOutput("timeout bus_valid", 32'(bus_valid), 32'h0);
        tick();
        #1;
        checkOutput("late rsp busy", 32'(busy), 32'h0);
        checkOutput("late rsp rsp_valid", 32'(rsp_valid), 32'h0);
        tick();
        applyStimulus(3'b000, 0, 0, 0, 32'h0);
        #1;
        checkOutput("late rsp idle rsp_valid", 32'(rsp_valid), 32'h0);
        tick();

        // Bus error on a write from requester 2.
        req_write = 3'b100;
        applyStimulus(3'b100, 0, 0, 0, 32'h0);
        #1;
        checkOutput("error req_ready", 32'(req_ready), 32'h4);
        tick();
        applyStimulus(3'b000, 1, 1, 1, 32'hFFFFFFFF);
        #1;
        checkOutput("error bus_write", 32'(bus_write), 32'h1);
        checkOutput("error bus_address", bus_address, 32'h2000);
        checkOutput("error bus_wdata", bus_wdata, 32'h55);
        tick();
        applyStimulus(3'b000, 0, 0, 0, 32'h0);
        #1;
        checkOutput("error rsp_valid", 32'(rsp_valid), 32'h4);
        checkOutput("error rsp_status", 32'(rsp_status), 32'h1);
        checkOutput("error rsp_rdata", rsp_rdata, 32'h0);
        tick();
        req_write = 3'b000;

        // Response arrives in the expiry cycle: the response wins.
        applyStimulus(3'b001, 0, 0, 0, 32'h0);
        #1;
        checkOutput("collision req_ready", 32'(req_ready), 32'h1);
        tick();
        applyStimulus(3'b000, 1, 0, 0, 32'h0);
        tick();
        applyStimulus(3'b000, 0, 0, 0, 32'h0);
        repeat (8) tick();
        applyStimulus(3'b000, 0, 1, 0, 32'h12345678);
        #1;
        checkOutput("collision no early rsp", 32'(rsp_valid), 32'h0);
        tick();
        applyStimulus(3'b000, 0, 0, 0, 32'h0);
        #1;
        checkOutput("collision rsp_valid", 32'(rsp_valid), 32'h1);
        checkOutput("collision rsp_status", 32'(rsp_status), 32'h0);
        checkOutput("collision rsp_rdata", rsp_rdata, 32'h12345678);
        tick();

        // Reset while waiting on the bus.
        applyStimulus(3'b010, 0, 0, 0, 32'h0);
        #1;
        checkOutput("rstwait req_ready", 32'(req_ready), 32'h2);
        tick();
        applyStimulus(3'b000, 1, 0, 0, 32'h0);
        tick();
        applyStimulus(3'b000, 0, 0, 0, 32'h0);
        tick();
        rst_n = 1'b0;
        applyStimulus(3'b011, 0, 0, 0, 32'h0);
        #1;
        checkOutput("rstwait busy", 32'(busy), 32'h0);
        checkOutput("rstwait bus_valid", 32'(bus_valid), 32'h0);
        checkOutput("rstwait rsp_valid", 32'(rsp_valid), 32'h0);
        checkOutput("rstwait req_ready", 32'(req_ready), 32'h0);
        tick();
        applyStimulus(3'b000, 0, 1, 0, 32'h99);
        #1;
        checkOutput("rstwait held rsp_valid", 32'(rsp_valid), 32'h0);
        tick();
        rst_n = 1'b1;
        applyStimulus(3'b000, 0, 0, 0, 32'h0);
        repeat (3) begin
            #1;
            checkOutput("rstwait release rsp_valid", 32'(rsp_valid), 32'h0);
            tick();
        end
        applyStimulus(3'b111, 0, 0, 0, 32'h0);
        #1;
        checkOutput("post-reset first grant", 32'(req_ready), 32'h1);
        tick();
        applyStimulus(3'b000, 1, 1, 0, 32'h77);
        #1;
        checkOutput("post-reset bus_address", bus_address, 32'h1000);
        tick();
        applyStimulus(3'b000, 0, 0, 0, 32'h0);
        #1;
        checkOutput("post-reset rsp_valid", 32'(rsp_valid), 32'h1);
        checkOutput("post-reset rsp_rdata", rsp_rdata, 32'h77);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
